// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external 16-bit ALU between NUM_REQ
// requesters, with one op in flight at a time.
module alu_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ALU_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [4*NUM_REQ-1:0]    req_op,
    input  logic [16*NUM_REQ-1:0]   req_a,
    input  logic [16*NUM_REQ-1:0]   req_b,
    input  logic [16*NUM_REQ-1:0]   req_c,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [15:0]             rsp_result,
    output logic                    rsp_zero,
    output logic [15:0]             alu_a,
    output logic [15:0]             alu_b,
    output logic [15:0]             alu_c,
    output logic [3:0]              alu_ctrl,
    input  logic [15:0]             alu_out,
    input  logic                    alu_z,
    output logic                    busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(ALU_LAT - 1);
    localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [3:0]         OP_BEQ   = 4'b1100;
    localparam logic [3:0]         OP_BNQ   = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic [CNT_W-1:0]   r_lat_cnt;
    logic [3:0]         r_op;
    logic [15:0]        r_a;
    logic [15:0]        r_b;
    logic [15:0]        r_c;
    logic [15:0]        r_rsp_result;
    logic               r_rsp_zero;

    logic               w_gnt_found;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_scan;
    logic [3:0]         w_sel_op;
    logic [15:0]        w_sel_a;
    logic [15:0]        w_sel_b;
    logic [15:0]        w_sel_c;
    logic               w_accept;
    logic               w_exec_last;

    // Scan rr_ptr+1, rr_ptr+2, ... so the last winner has the lowest priority.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_scan = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ);
            if (!w_gnt_found && req_valid[w_scan]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan;
            end
        end
    end

    always_comb begin
        w_sel_op = req_op[{w_gnt_idx, 2'b00} +: 4];
        w_sel_a  = req_a[{w_gnt_idx, 4'b0000} +: 16];
        w_sel_b  = req_b[{w_gnt_idx, 4'b0000} +: 16];
        w_sel_c  = req_c[{w_gnt_idx, 4'b0000} +: 16];
    end

    assign w_accept    = (r_state == S_IDLE) && w_gnt_found;
    assign w_exec_last = (r_state == S_EXEC) && (r_lat_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_found) w_state_nxt = S_EXEC;
            S_EXEC:  if (r_lat_cnt == LAST_CNT) w_state_nxt = S_DONE;
            S_DONE:  if (rsp_ready[r_gnt_idx]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; all registers get explicit reset values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= PTR_RST;
            r_gnt_idx    <= '0;
            r_lat_cnt    <= '0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr_ptr  <= w_gnt_idx;
                r_gnt_idx <= w_gnt_idx;
                r_lat_cnt <= '0;
                r_op      <= w_sel_op;
                r_a       <= w_sel_a;
                r_b       <= w_sel_b;
                r_c       <= w_sel_c;
            end else if (r_state == S_EXEC) begin
                r_lat_cnt <= r_lat_cnt + CNT_W'(1);
            end
            if (w_exec_last) begin
                r_rsp_result <= alu_out;
                r_rsp_zero   <= ((r_op == OP_BEQ) || (r_op == OP_BNQ)) && alu_z;
            end
        end
    end

    // NOTE: req_ready is combinational from req_valid, so it is masked by rst
    // to keep every output at zero while reset is held.
    assign req_ready  = (w_accept && !rst) ? (ONE_HOT0 << w_gnt_idx) : '0;
    assign rsp_valid  = (r_state == S_DONE) ? (ONE_HOT0 << r_gnt_idx) : '0;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign alu_ctrl   = r_op;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_c      = r_c;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: behavioural ALU, accept-time
// scoreboard, and directed scenario tasks for ALU_LAT=1 and ALU_LAT=3.
module tb_alu_share_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      rsp_ready;
    logic [4*N-1:0]    req_op;
    logic [16*N-1:0]   req_a;
    logic [16*N-1:0]   req_b;
    logic [16*N-1:0]   req_c;

    logic [N-1:0]      req_ready,  req_ready3;
    logic [N-1:0]      rsp_valid,  rsp_valid3;
    logic [15:0]       rsp_result, rsp_result3;
    logic              rsp_zero,   rsp_zero3;
    logic [15:0]       alu_a, alu_b, alu_c, alu_out;
    logic [15:0]       alu_a3, alu_b3, alu_c3, alu_out3;
    logic [3:0]        alu_ctrl, alu_ctrl3;
    logic              alu_z, alu_z3;
    logic              busy, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: {zero, result}; unknown encodings fall back to add.
    function automatic logic [16:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] c);
        logic [15:0] r;
        case (op)
            4'b0111: r = a + b;
            4'b1000: r = a * b;
            4'b1001: r = a + b * c;
            4'b1010: r = {15'd0, a < b};
            4'b1100: r = a - b;
            4'b1101: r = {15'd0, a == b};
            default: r = a + b;
        endcase
        return {r == 16'd0, r};
    endfunction

    assign {alu_z, alu_out}   = alu_model(alu_ctrl, alu_a, alu_b, alu_c);
    assign {alu_z3, alu_out3} = alu_model(alu_ctrl3, alu_a3, alu_b3, alu_c3);

    alu_share_arbiter #(.NUM_REQ(N), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_z(alu_z), .busy(busy)
    );

    alu_share_arbiter #(.NUM_REQ(N), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready3), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result3), .rsp_zero(rsp_zero3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3), .alu_ctrl(alu_ctrl3),
        .alu_out(alu_out3), .alu_z(alu_z3), .busy(busy3)
    );

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic        z;
    } exp_t;

    exp_t sb[$];

    // Scoreboard for the ALU_LAT=1 instance: push on accept, pop on response.
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [16:0] m;
        logic [3:0]  op;
        if (rst) begin
            sb.delete();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    op    = req_op[4*i +: 4];
                    m     = alu_model(op, req_a[16*i +: 16], req_b[16*i +: 16], req_c[16*i +: 16]);
                    e.idx = i;
                    e.res = m[15:0];
                    e.z   = (op == 4'b1100 || op == 4'b1101) ? m[16] : 1'b0;
                    sb.push_back(e);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_rsp req %0d result %0d", i, rsp_result);
                    end else begin
                        e = sb.pop_front();
                        if (e.idx != i || rsp_result !== e.res || rsp_zero !== e.z) begin
                            errors++;
                            $display("FAIL sb_rsp got req %0d res %0d z %b, expected req %0d res %0d z %b",
                                     i, rsp_result, rsp_zero, e.idx, e.res, e.z);
                        end
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] c);
        req_op[4*i +: 4]  = op;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_c[16*i +: 16] = c;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Holds req i valid until the LAT=1 instance accepts it (bounded).
    task automatic send_op(input int i);
        bit got = 0;
        @(posedge clk);
        #1;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout req %0d req_ready %b", i, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i);
        bit got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (rsp_valid[i]) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout req %0d rsp_valid %b", i, rsp_valid);
        end
    endtask

    task automatic drain();
        bit idle = 0;
        for (int k = 0; k < 30 && !idle; k++) begin
            @(negedge clk);
            if (!busy && !busy3) idle = 1;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout busy %b busy3 %b", busy, busy3);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) set_req(i, 4'b0111, 16'd1, 16'd1, 16'd0);
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake req_ready %b rsp_valid %b busy %b, expected 0", req_ready, rsp_valid, busy);
        end
        checks++;
        if (alu_ctrl !== 4'b0000 || alu_a !== 16'd0 || alu_b !== 16'd0 || alu_c !== 16'd0) begin
            errors++;
            $display("FAIL reset_alu ctrl %b a %0d b %0d c %0d, expected 0", alu_ctrl, alu_a, alu_b, alu_c);
        end
        checks++;
        if (rsp_result !== 16'd0 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp result %0d zero %b, expected 0", rsp_result, rsp_zero);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single_op();
        @(posedge clk);
        #1;
        set_req(0, 4'b0111, 16'd5, 16'd7, 16'd0);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got %b expected 0001", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_exec rsp_valid %b busy %b, expected 0000/1", rsp_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 16'd12) begin
            errors++;
            $display("FAIL single_rsp rsp_valid %b result %0d, expected 0001/12", rsp_valid, rsp_result);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_drop rsp_valid %b expected 0000", rsp_valid);
        end
    endtask

    task automatic test_contention();
        int g    = 0;
        int last = 0;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'b1000, 16'd3, 16'd4, 16'd0);
        req_valid = '1;
        for (int c = 0; c < 40 && g < 5; c++) begin
            @(negedge clk);
            if (req_ready !== '0) begin
                checks++;
                if (req_ready !== (4'b0001 << (g % N))) begin
                    errors++;
                    $display("FAIL contention_order grant %0d got %b expected %b", g, req_ready, 4'b0001 << (g % N));
                end
                if (g > 0) begin
                    checks++;
                    if (c - last != 3) begin
                        errors++;
                        $display("FAIL contention_spacing grant %0d got %0d cycles expected 3", g, c - last);
                    end
                end
                last = c;
                g++;
            end
        end
        checks++;
        if (g != 5) begin
            errors++;
            $display("FAIL contention_grants got %0d expected 5", g);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = '0;
        set_req(2, 4'b1001, 16'd1, 16'd2, 16'd3);
        set_req(0, 4'b0111, 16'd1, 16'd1, 16'd0);
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_accept got %b expected 0100", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 4'b0100 || rsp_result !== 16'd7 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold cycle %0d rsp_valid %b result %0d req_ready %b, expected 0100/7/0000",
                         k, rsp_valid, rsp_result, req_ready);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 4'b1011;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0100 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_other_ready rsp_valid %b req_ready %b, expected 0100/0000", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        rsp_ready = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0000 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release rsp_valid %b req_ready %b, expected 0000/0001", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = '1;
        drain();
    endtask

    task automatic test_zero_flag();
        logic [3:0]  ops [3] = '{4'b1100, 4'b1101, 4'b0111};
        logic [15:0] as  [3] = '{16'd9, 16'd9, 16'd0};
        logic [15:0] bs  [3] = '{16'd9, 16'd9, 16'd0};
        logic        zs  [3] = '{1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            set_req(1, ops[k], as[k], bs[k], 16'd0);
            send_op(1);
            wait_rsp(1);
            checks++;
            if (rsp_zero !== zs[k]) begin
                errors++;
                $display("FAIL zero_flag op %b got %b expected %b", ops[k], rsp_zero, zs[k]);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        set_req(1, 4'b0111, 16'd100, 16'd23, 16'd0);
        send_op(1);
        wait_rsp(1);
        drain();
        @(posedge clk);
        #1;
        set_req(3, 4'b1000, 16'd6, 16'd7, 16'd0);
        req_valid = 4'b1000;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL mid_accept got %b expected 1000", req_ready);
        end
        @(posedge clk);
        #2;
        req_valid = '1;
        rst       = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== '0 || req_ready !== '0 || busy !== 1'b0 || rsp_result !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_out rsp_valid %b req_ready %b busy %b result %0d, expected 0",
                     rsp_valid, req_ready, busy, rsp_result);
        end
        checks++;
        if (alu_ctrl !== 4'b0000 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset_alu ctrl %b a %0d b %0d, expected 0", alu_ctrl, alu_a, alu_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_next_grant got %b expected 0001", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        drain();
    endtask

    task automatic test_lat3();
        int  k;
        bit  got = 0;
        do_reset();
        set_req(1, 4'b1010, 16'd2, 16'd5, 16'd0);
        req_valid = 4'b0010;
        @(negedge clk);
        checks++;
        if (req_ready3 !== 4'b0010) begin
            errors++;
            $display("FAIL lat3_accept got %b expected 0010", req_ready3);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        for (k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid3 !== '0) got = 1;
        end
        checks++;
        if (!got || k - 1 != 4 || rsp_valid3 !== 4'b0010 || rsp_result3 !== 16'd1) begin
            errors++;
            $display("FAIL lat3_rsp cycles %0d rsp_valid %b result %0d, expected 4/0010/1",
                     k - 1, rsp_valid3, rsp_result3);
        end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_zero_flag();
        test_reset_mid_exec();
        test_lat3();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
